// File: rtl/cos_ctrl_pkg.sv
// cos_ctrl_pkg: state encoding and sizing shared by the cos(x) controller.
package cos_ctrl_pkg;
  localparam int ADDR_W = 3;
  localparam int LAST_ADDR_DEF = 7;
  typedef enum logic [3:0] {
    IDLE, WAIT_LOW, INIT, LOAD, SQUARE, MUL_X2, MUL_ROM, ACC, DONE
  } state_t;
endpackage

// File: rtl/cos_controller.sv
// cos_controller: Moore FSM sequencing the cos(x) Taylor datapath.
// Optional COS_EARLY_EXIT_EN: lt in ACC ends the series before LAST_ADDR.
module cos_controller
  import cos_ctrl_pkg::*;
#(
  parameter int LAST_ADDR = LAST_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lt,
  output logic       done,
  output logic       ldx_x,
  output logic       ldx_x2,
  output logic       ldx_t,
  output logic       ldx_r,
  output logic       ld1_x,
  output logic       ld1_x2,
  output logic       ld1_t,
  output logic       ld1_r,
  output logic       selx_2to1,
  output logic       selx_3to1,
  output logic       selx2,
  output logic       selrom,
  output logic       selt,
  output logic       seladd,
  output logic [2:0] addr
);
`ifdef COS_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_t state, nxt;
  logic stop;
  assign stop = addr == LAST_ADDR[ADDR_W-1:0] || (EARLY && lt);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
    end else begin
      state <= nxt;
      if (state == INIT) addr <= '0;
      else if (state == ACC && !stop) addr <= addr + 1'b1;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? WAIT_LOW : IDLE;
      WAIT_LOW: nxt = start ? WAIT_LOW : INIT;
      INIT:     nxt = LOAD;
      LOAD:     nxt = SQUARE;
      SQUARE:   nxt = MUL_X2;
      MUL_X2:   nxt = MUL_ROM;
      MUL_ROM:  nxt = ACC;
      ACC:      nxt = stop ? DONE : MUL_X2;
      default:  nxt = IDLE;
    endcase
  end
  assign done = state == DONE;
  assign ld1_x = state == INIT;
  assign ld1_x2 = state == INIT;
  assign ld1_t = state == INIT;
  assign ld1_r = state == INIT;
  assign ldx_x = state == LOAD;
  assign ldx_x2 = state == SQUARE;
  assign ldx_t = state == MUL_X2 || state == MUL_ROM;
  assign ldx_r = state == ACC;
  assign selx_2to1 = ldx_t;
  assign selt = ldx_t;
  assign selx_3to1 = state == SQUARE;
  assign selx2 = state == MUL_X2;
  assign selrom = state == MUL_ROM;
  // even term index subtracts, odd adds
  assign seladd = state == ACC && addr[0];
endmodule

// File: tb/tb_cos_controller.sv
// tb_cos_controller: directed and random stimulus against a schedule-based model of the controller.
module tb_cos_controller;
  import cos_ctrl_pkg::*;
  localparam int L = LAST_ADDR_DEF;
`ifdef COS_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, lt = 0;
  logic done, ldx_x, ldx_x2, ldx_t, ldx_r, ld1_x, ld1_x2, ld1_t, ld1_r;
  logic selx_2to1, selx_3to1, selx2, selrom, selt, seladd;
  logic [2:0] addr;
  int checks = 0, errors = 0;

  cos_controller dut (
    .clk(clk), .rst(rst), .start(start), .lt(lt), .done(done),
    .ldx_x(ldx_x), .ldx_x2(ldx_x2), .ldx_t(ldx_t), .ldx_r(ldx_r),
    .ld1_x(ld1_x), .ld1_x2(ld1_x2), .ld1_t(ld1_t), .ld1_r(ld1_r),
    .selx_2to1(selx_2to1), .selx_3to1(selx_3to1), .selx2(selx2),
    .selrom(selrom), .selt(selt), .seladd(seladd), .addr(addr)
  );

  always #5 clk = ~clk;

  // {done, ldx x/x2/t/r, ld1 x/x2/t/r, sel 2to1/3to1/x2/rom/t/add, addr}
  wire [17:0] outs = {done, ldx_x, ldx_x2, ldx_t, ldx_r, ld1_x, ld1_x2, ld1_t, ld1_r,
                      selx_2to1, selx_3to1, selx2, selrom, selt, seladd, addr};

  function automatic logic [17:0] mk(logic d, logic [3:0] ldx, logic [3:0] ld1, logic [5:0] sel, logic [2:0] a);
    return {d, ldx, ld1, sel, a};
  endfunction

  // model: a launch enqueues the whole expected cycle-by-cycle schedule of a run
  logic [17:0] q[$];
  logic [17:0] cur = '0;
  bit armed = 0, hold = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); cur = '0; armed = 0; hold = 0;
    end else if (hold) begin
      hold = 0; cur = {15'b0, cur[2:0]};
    end else if (EE && lt && cur[13]) begin
      q.delete(); cur = mk(1, 0, 0, 0, cur[2:0]); hold = 1;
    end else if (q.size() != 0) begin
      cur = q.pop_front(); hold = cur[17];
    end else if (armed && !start) begin
      armed = 0;
      q.push_back(mk(0, 4'b0000, 4'b1111, 6'b000000, cur[2:0]));
      q.push_back(mk(0, 4'b1000, 4'b0000, 6'b000000, 3'd0));
      q.push_back(mk(0, 4'b0100, 4'b0000, 6'b010000, 3'd0));
      for (int k = 0; k <= L; k++) begin
        q.push_back(mk(0, 4'b0010, 4'b0000, 6'b101010, 3'(k)));
        q.push_back(mk(0, 4'b0010, 4'b0000, 6'b100110, 3'(k)));
        q.push_back(mk(0, 4'b0001, 4'b0000, {5'b0, 1'(k % 2)}, 3'(k)));
      end
      q.push_back(mk(1, 0, 0, 0, 3'(L)));
      cur = q.pop_front();
    end else begin
      if (start) armed = 1;
      cur = {15'b0, cur[2:0]};
    end
  end

  always @(negedge clk) if (!rst) begin
    checks++;
    if (outs !== cur) begin
      errors++;
      $display("FAIL cycle_outs t=%0t actual=%h required=%h", $time, outs, cur);
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #2;
  endtask

  int accs[$];
  int adds[$];

  task automatic run(input int hi, input bit lt_at2, output int lat);
    accs.delete(); adds.delete();
    start = 1;
    repeat (hi) tick;
    start = 0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      lt = lt_at2 && cur[13] && cur[2:0] == 3'd2;
      tick;
      if (ldx_r) begin accs.push_back(int'(addr)); adds.push_back(int'(seladd)); end
      if (done) begin lat = i; break; end
    end
    lt = 0;
  endtask

  int lat, n;
  initial begin
    repeat (2) tick;
    chk("reset_outs", 32'(outs), 0);
    rst = 0;
    tick;
    chk("idle_outs", 32'(outs), 0);

    run(1, 0, lat);
    chk("latency_run1", lat, 28);
    chk("acc_count", accs.size(), L + 1);
    for (int i = 0; i < accs.size(); i++) begin
      chk("acc_addr", accs[i], i);
      chk("acc_seladd", adds[i], i % 2);
    end
    chk("done_addr", addr, L);
    tick;
    chk("done_one_cycle", done, 0);

    n = 0;
    start = 1;
    for (int i = 0; i < 5; i++) begin tick; n += int'(ld1_x); end
    chk("held_start_no_init", n, 0);
    run(1, 0, lat);
    chk("latency_held", lat, 28);
    start = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin tick; n += int'(ld1_x); end
    chk("no_relaunch", n, 0);
    start = 0;
    tick; tick;

    start = 1; tick; start = 0;
    n = 0;
    while (!(selrom && addr == 3'd3) && n < 60) begin tick; n++; end
    chk("reach_mulrom3", int'(n < 60), 1);
    rst = 1;
    #1;
    chk("async_reset_outs", 32'(outs), 0);
    tick;
    rst = 0;
    run(1, 0, lat);
    chk("latency_after_abort", lat, 28);

    for (int r = 0; r < 3; r++) begin
      rst = 1; tick; rst = 0; tick;
      run(1, 0, lat);
      chk("latency_b2b", lat, 28);
      tick;
    end

    run(1, 1, lat);
    chk("early_addr", addr, EE ? 2 : L);
    chk("early_latency", lat, EE ? 13 : 28);
    tick;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) start = ~start;
      lt = 1'($urandom);
      if ($urandom_range(0, 400) == 0) begin rst = 1; tick; rst = 0; end
      tick;
    end
    start = 0; lt = 0;
    repeat (40) tick;
    run(2, 0, lat);
    chk("latency_final", lat, 28);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
